// File: rtl/pulse_cond_pkg.sv
// Shared types and helpers for the multi-channel pulse conditioner.
package pulse_cond_pkg;

  // Per-channel edge selection; the encoding matches the mode_i bit pairs.
  typedef enum logic [1:0] {
    OFF  = 2'b00,
    RISE = 2'b01,
    FALL = 2'b10,
    BOTH = 2'b11
  } edge_mode_t;

  // Per-channel sequencing state.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_HOLDOFF = 2'd2
  } chan_state_t;

  // Larger of two integers, used to size the shared stretch/hold-off counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Qualify raw rise/fall indications with the selected edge mode.
  function automatic logic edge_event(input edge_mode_t mode,
                                      input logic rise,
                                      input logic fall);
    logic rise_en;
    logic fall_en;
    rise_en = (mode == RISE) || (mode == BOTH);
    fall_en = (mode == FALL) || (mode == BOTH);
    return (rise_en & rise) | (fall_en & fall);
  endfunction

endpackage

// File: rtl/pulse_cond_chan.sv
// One conditioner channel: input synchroniser, edge detector, and an
// IDLE -> ACTIVE -> HOLDOFF sequencer driving a one-cycle pulse, a stretched
// level and a sticky overrun flag.
//
// There is no handshake on this block: inputs are sampled every clock and
// every output is a registered level. pulse_o is high for exactly one cycle
// per accepted event; stretch_o and overrun_o are plain levels.
module pulse_cond_chan
  import pulse_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 12,
  parameter int HOLDOFF     = 4
) (
  input  logic        sync_clk,
  input  logic        rst,
  input  logic        in_i,
  input  logic [1:0]  mode_i,
  input  logic        retrig_i,
  input  logic        clr_i,
  output logic        pulse_o,
  output logic        stretch_o,
  output logic        overrun_o,
  output chan_state_t state_o
);

  // One counter serves both the stretch and the hold-off phases.
  localparam int CNT_MAX = max_int(STRETCH, HOLDOFF);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Values loaded into the counter on phase entry; the counter expires at 0.
  localparam logic [CNT_W-1:0] STR_LOAD = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] HO_LOAD  = CNT_W'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   last_s;
  logic                   rise_s;
  logic                   fall_s;
  logic                   evt_s;
  chan_state_t            state_q;
  logic [CNT_W-1:0]       cnt_q;

  assign last_s  = sync_q[SYNC_STAGES-1];
  assign state_o = state_q;

  // Synchroniser chain plus one extra flop holding the previous synced value.
  always_ff @(posedge sync_clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
      prev_q <= last_s;
    end
  end

  // Raw edges from the synced level, then gated by the live mode selection.
  always_comb begin
    rise_s = last_s & ~prev_q;
    fall_s = ~last_s & prev_q;
    evt_s  = edge_event(edge_mode_t'(mode_i), rise_s, fall_s);
  end

  // Sequencer: pulse/stretch generation, counter, and the sticky overrun flag.
  always_ff @(posedge sync_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pulse_o   <= 1'b0;
      stretch_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      // The pulse is only ever raised from IDLE, so it can never last longer
      // than one cycle even with the input held at the active level.
      pulse_o <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (evt_s) begin
            pulse_o   <= 1'b1;
            stretch_o <= 1'b1;
            cnt_q     <= STR_LOAD;
            state_q   <= S_ACTIVE;
          end
        end

        S_ACTIVE: begin
          // A retriggering event beats expiry in the same cycle.
          if (evt_s && retrig_i) begin
            cnt_q <= STR_LOAD;
          end else if (cnt_q == '0) begin
            stretch_o <= 1'b0;
            if (HOLDOFF > 0) begin
              cnt_q   <= HO_LOAD;
              state_q <= S_HOLDOFF;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_HOLDOFF: begin
          // Events are dropped here without flagging overrun.
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        default: begin
          state_q   <= S_IDLE;
          cnt_q     <= '0;
          stretch_o <= 1'b0;
        end
      endcase

      // A new overrun takes priority over a simultaneous clear.
      if ((state_q == S_ACTIVE) && evt_s && !retrig_i) begin
        overrun_o <= 1'b1;
      end else if (clr_i) begin
        overrun_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pulse_condition_multi.sv
// Multi-channel pulse conditioner: CHANNELS independent copies of
// pulse_cond_chan sharing one clock, one reset and one overrun clear.
// dbg_state_o carries each channel's sequencer state (2 bits per channel,
// same slicing as mode_i) for observation only.
module pulse_condition_multi
  import pulse_cond_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 12,
  parameter int HOLDOFF     = 4
) (
  input  logic                  sync_clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   in_i,
  input  logic [2*CHANNELS-1:0] mode_i,
  input  logic [CHANNELS-1:0]   retrig_i,
  input  logic                  clr_i,
  output logic [CHANNELS-1:0]   pulse_o,
  output logic [CHANNELS-1:0]   stretch_o,
  output logic [CHANNELS-1:0]   overrun_o,
  output logic [2*CHANNELS-1:0] dbg_state_o
);

  // One channel per input bit; channels never interact.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    chan_state_t state_s;

    pulse_cond_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .STRETCH     (STRETCH),
      .HOLDOFF     (HOLDOFF)
    ) u_chan (
      .sync_clk  (sync_clk),
      .rst       (rst),
      .in_i      (in_i[g]),
      .mode_i    (mode_i[2*g +: 2]),
      .retrig_i  (retrig_i[g]),
      .clr_i     (clr_i),
      .pulse_o   (pulse_o[g]),
      .stretch_o (stretch_o[g]),
      .overrun_o (overrun_o[g]),
      .state_o   (state_s)
    );

    assign dbg_state_o[2*g +: 2] = state_s;
  end

endmodule

// File: tb/tb_pulse_condition_multi.sv
// Bench for pulse_condition_multi. A timeline model tracks, per channel, the
// clock index at which the current stretch ends; acceptance, retrigger,
// overrun and hold-off are decided from that index alone.
module tb_pulse_condition_multi;
  import pulse_cond_pkg::*;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int ST = 12;
  localparam int HO = 4;

  logic              sync_clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     in_i;
  logic [2*CH-1:0]   mode_i;
  logic [CH-1:0]     retrig_i;
  logic              clr_i;
  logic [CH-1:0]     pulse_o;
  logic [CH-1:0]     stretch_o;
  logic [CH-1:0]     overrun_o;
  logic [2*CH-1:0]   dbg_state_o;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state.
  logic [CH-1:0] hist[$];
  int            end_t[CH];
  logic [CH-1:0] exp_pulse;
  logic [CH-1:0] exp_stretch;
  logic [CH-1:0] exp_over;
  int            cyc = 0;

  // Observed activity counters for directed checks.
  int pulse_cnt[CH];
  int stretch_cnt[CH];

  pulse_condition_multi #(
    .CHANNELS    (CH),
    .SYNC_STAGES (SS),
    .STRETCH     (ST),
    .HOLDOFF     (HO)
  ) dut (
    .sync_clk    (sync_clk),
    .rst         (rst),
    .in_i        (in_i),
    .mode_i      (mode_i),
    .retrig_i    (retrig_i),
    .clr_i       (clr_i),
    .pulse_o     (pulse_o),
    .stretch_o   (stretch_o),
    .overrun_o   (overrun_o),
    .dbg_state_o (dbg_state_o)
  );

  // Clock.
  always #5 sync_clk = ~sync_clk;

  // Advance the model by one clock edge using the inputs present at that edge.
  // An event decided at edge e comes from the input sampled at edge e-SS.
  task automatic model_step();
    logic [CH-1:0] lastv;
    logic [CH-1:0] prevv;
    logic [1:0]    m;
    logic          rise;
    logic          fall;
    logic          ev;
    logic          acc;
    logic          ovs;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < SS + 1; i++) hist.push_back('0);
      for (int c = 0; c < CH; c++) end_t[c] = -1000;
      exp_pulse   = '0;
      exp_stretch = '0;
      exp_over    = '0;
    end else begin
      prevv = hist[0];
      lastv = hist[1];
      for (int c = 0; c < CH; c++) begin
        rise = lastv[c] & ~prevv[c];
        fall = ~lastv[c] & prevv[c];
        m    = mode_i[2*c +: 2];
        ev   = (m[0] & rise) | (m[1] & fall);
        acc  = 1'b0;
        ovs  = 1'b0;
        if (ev) begin
          if (cyc > end_t[c] + HO) begin
            acc      = 1'b1;
            end_t[c] = cyc + ST;
          end else if (cyc <= end_t[c]) begin
            if (retrig_i[c]) end_t[c] = cyc + ST;
            else ovs = 1'b1;
          end
        end
        exp_pulse[c]   = acc;
        exp_stretch[c] = (cyc < end_t[c]);
        exp_over[c]    = ovs ? 1'b1 : (clr_i ? 1'b0 : exp_over[c]);
      end
      void'(hist.pop_front());
      hist.push_back(in_i);
    end
  endtask

  task automatic check_outputs();
    tests_run++;
    assert (pulse_o === exp_pulse) else begin
      tests_failed++;
      $error("FAIL pulse cyc=%0d got=%b exp=%b", cyc, pulse_o, exp_pulse);
    end
    tests_run++;
    assert (stretch_o === exp_stretch) else begin
      tests_failed++;
      $error("FAIL stretch cyc=%0d got=%b exp=%b", cyc, stretch_o, exp_stretch);
    end
    tests_run++;
    assert (overrun_o === exp_over) else begin
      tests_failed++;
      $error("FAIL overrun cyc=%0d got=%b exp=%b", cyc, overrun_o, exp_over);
    end
  endtask

  task automatic check_val(input string tag, input int got, input int exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock: update model at the edge, compare 1 time unit later.
  task automatic tick();
    @(posedge sync_clk);
    model_step();
    cyc++;
    #1;
    check_outputs();
    for (int c = 0; c < CH; c++) begin
      pulse_cnt[c]   += int'(pulse_o[c]);
      stretch_cnt[c] += int'(stretch_o[c]);
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_counts();
    for (int c = 0; c < CH; c++) begin
      pulse_cnt[c]   = 0;
      stretch_cnt[c] = 0;
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_i     = '0;
    mode_i   = '0;
    retrig_i = '0;
    clr_i    = 1'b0;
    clear_counts();

    // Reset state.
    run(3);
    check_val("reset_state_ch0", int'(dbg_state_o[1:0]), int'(S_IDLE));
    check_val("reset_pulse", int'(pulse_o), 0);
    rst = 1'b0;
    run(4);

    // ch0 rising, held high 50 clocks.
    mode_i[1:0] = 2'b01;
    clear_counts();
    in_i[0] = 1'b1;
    run(2);
    check_val("t1_no_early_pulse", pulse_cnt[0], 0);
    run(1);
    check_val("t1_pulse_after_e2", int'(pulse_o[0]), 1);
    run(47);
    check_val("t1_pulse_count", pulse_cnt[0], 1);
    check_val("t1_stretch_len", stretch_cnt[0], ST);

    // ch1 both edges, 20 clocks high.
    mode_i[3:2] = 2'b11;
    clear_counts();
    in_i[1] = 1'b1;
    run(20);
    in_i[1] = 1'b0;
    run(30);
    check_val("t2_pulse_count", pulse_cnt[1], 2);
    check_val("t2_stretch_len", stretch_cnt[1], 2 * ST);

    // ch1 both edges, 8 clocks high: the fall lands inside the stretch.
    clear_counts();
    in_i[1] = 1'b1;
    run(8);
    in_i[1] = 1'b0;
    run(30);
    check_val("t2b_pulse_count", pulse_cnt[1], 1);
    check_val("t2b_overrun", int'(overrun_o[1]), 1);
    clr_i = 1'b1;
    run(1);
    clr_i = 1'b0;
    check_val("t2b_overrun_clr", int'(overrun_o[1]), 0);

    // ch2 retrigger on: three rises 6 clocks apart.
    mode_i[5:4] = 2'b01;
    retrig_i[2] = 1'b1;
    clear_counts();
    repeat (3) begin
      in_i[2] = 1'b1;
      run(3);
      in_i[2] = 1'b0;
      run(3);
    end
    run(30);
    check_val("t3_pulse_count", pulse_cnt[2], 1);
    check_val("t3_stretch_len", stretch_cnt[2], 24);
    check_val("t3_no_overrun", int'(overrun_o[2]), 0);

    // ch2 retrigger off: same stimulus.
    retrig_i[2] = 1'b0;
    clear_counts();
    repeat (3) begin
      in_i[2] = 1'b1;
      run(3);
      in_i[2] = 1'b0;
      run(3);
    end
    run(30);
    check_val("t4_pulse_count", pulse_cnt[2], 1);
    check_val("t4_stretch_len", stretch_cnt[2], ST);
    check_val("t4_overrun_set", int'(overrun_o[2]), 1);
    clr_i = 1'b1;
    run(1);
    clr_i = 1'b0;
    check_val("t4_overrun_clr", int'(overrun_o[2]), 0);

    // ch3 hold-off: an edge 2 clocks after the fall is dropped, 5 after is taken.
    mode_i[7:6] = 2'b01;
    clear_counts();
    in_i[3] = 1'b1;
    run(4);
    in_i[3] = 1'b0;
    run(10);
    in_i[3] = 1'b1;
    run(2);
    in_i[3] = 1'b0;
    run(1);
    in_i[3] = 1'b1;
    run(20);
    check_val("t5_pulse_count", pulse_cnt[3], 2);
    check_val("t5_no_overrun", int'(overrun_o[3]), 0);

    // Randomised traffic on all channels.
    for (int k = 0; k < 300; k++) begin
      if (k % 40 == 0) begin
        mode_i   = 2*CH'($urandom);
        retrig_i = CH'($urandom);
      end
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 4) == 0) in_i[c] = ~in_i[c];
      clr_i = ($urandom_range(0, 15) == 0);
      tick();
    end
    clr_i = 1'b0;

    // Reset in the middle of a stretch on every channel.
    mode_i   = {CH{2'b01}};
    retrig_i = '0;
    in_i     = '0;
    run(30);
    in_i = '1;
    run(5);
    check_val("t6_stretching", int'(stretch_o), (1 << CH) - 1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check_val("t6_reset_stretch", int'(stretch_o), 0);
    clear_counts();
    run(2);
    check_val("t6_no_early_pulse", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], 0);
    run(1);
    check_val("t6_pulse_after_reset", int'(pulse_o), (1 << CH) - 1);
    run(20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pulse_condition_multi.md
Name: pulse_condition_multi

Overview:
Multi-channel pulse conditioner in one clock domain. Each channel synchronises an asynchronous control input, detects a selectable edge and emits a one-cycle pulse plus a stretched level of programmable length. After each stretch the channel ignores edges for a programmable hold-off time. Overrun is flagged per channel. It sits between raw tester control lines and the sequencing logic.

Parameters:
CHANNELS, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
STRETCH, 12, stretch_o high time in clocks (>=1)
HOLDOFF, 4, dead time after stretch in clocks (>=0)
CNT_W, $clog2(max(STRETCH,HOLDOFF)+1), counter width (derived, not overridden)

Ports:
sync_clk  in  1  sole clock
rst  in  1  synchronous active-high reset
in_i  in  CHANNELS  asynchronous channel inputs
mode_i  in  2*CHANNELS  per-channel edge select (ch n = bits [2n+1:2n]): 00 off, 01 rise, 10 fall, 11 both
retrig_i  in  CHANNELS  per-channel retrigger enable
clr_i  in  1  clears all overrun_o bits
pulse_o  out  CHANNELS  one-cycle event pulse
stretch_o  out  CHANNELS  stretched level
overrun_o  out  CHANNELS  sticky: edge arrived while ACTIVE with retrigger off

Behaviour:
- Interface: one clock, sync_clk; reset rst is synchronous and active-high.
- Reset: sync chain, prev flop, counters, pulse_o, stretch_o and overrun_o all go to 0. State goes to IDLE. Reset mid-stretch aborts the stretch immediately.
- If in_i is high at reset release, the channel sees a rising edge after the sync chain fills. This is intended.
- Sync: in_i passes through SYNC_STAGES flops. prev holds the last stage delayed by one clock.
- Event (combinational): rise = last & ~prev; fall = ~last & prev; gated by mode_i.
- Latency: with in_i settled before sampling edge E0, pulse_o and stretch_o are high after edge E(SYNC_STAGES).
- Per-channel FSM:
  - IDLE: on event, assert pulse_o for 1 cycle, set stretch_o, load cnt = STRETCH-1, go to ACTIVE.
  - ACTIVE: stretch_o = 1.
    - If cnt == 0: stretch_o drops next cycle. Go to HOLDOFF with cnt = HOLDOFF-1 if HOLDOFF > 0, otherwise go to IDLE.
    - Else cnt decrements.
    - Event with retrig_i = 1: reload cnt = STRETCH-1, no new pulse_o.
    - Event with retrig_i = 0: ignored, overrun_o set.
    - An event in the same cycle as cnt == 0 follows the same retrigger/overrun rule (retrigger wins over exit).
  - HOLDOFF: events ignored, no overrun. When cnt == 0 go to IDLE; an event in that same cycle is also ignored. Otherwise cnt decrements.
- STRETCH = 1: stretch_o equals pulse_o.
- pulse_o width is always exactly 1 cycle, including when in_i is held high indefinitely.
- mode_i and retrig_i are sampled each cycle. A change to them affects only later events. Setting 00 while ACTIVE lets the current stretch finish.
- clr_i clears overrun_o next cycle. If clr_i and a new overrun occur in the same cycle, the set wins.
- Channels are fully independent. There is no cross-channel arbitration.

Decomposition:
- Package pulse_cond_pkg holds:
  - edge_mode_t enum (OFF, RISE, FALL, BOTH), 2 bits.
  - chan_state_t enum (IDLE, ACTIVE, HOLDOFF).
- Sub-module pulse_cond_chan implements one channel (sync, edge detect, FSM, counter). The top instantiates it CHANNELS times in a generate loop and does the port slicing.

Test Plan:
- Default params, ch0 mode 01: in_i[0] rises before E0 and is held high 50 clocks. Required: pulse_o[0] high only after E2 for 1 clock; stretch_o[0] high exactly 12 clocks; no second pulse.
- ch1 mode 11, in_i[1] high for 20 clocks then low. Required: two pulses 20 clocks apart, each with a 12-clock stretch. A fall at 8 clocks with HOLDOFF=4 yields no pulse; at 20 clocks it is accepted.
- ch2 mode 01, retrig 1: rising edges 6 clocks apart, three times. Required: one pulse_o; stretch_o continuous for 6+6+12 = 24 clocks; overrun_o[2] stays 0.
- Same stimulus with retrig 0. Required: stretch_o 12 clocks; overrun_o[2] = 1 until clr_i is pulsed, then 0 next cycle.
- Edge arriving 2 clocks after stretch_o falls (during HOLDOFF). Required: ignored, no overrun. The same edge 5 clocks after the fall produces a pulse.
- rst asserted for 1 clock mid-stretch on all channels. Required: all outputs 0 next cycle; with in_i held high, new pulses appear SYNC_STAGES+1 edges after rst deasserts.
